// File: rtl/cn_pkg.sv
// Shared definitions for the check-node minimum search and the merge stage.
// Holds the controller state encoding, default widths and the all-ones helper.
package cn_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int IDX_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // All-ones value of the given width, used as the "no minimum yet" seed.
   function automatic logic [63:0] max_mag(input int unsigned w);
      return ~64'd0 >> (64 - w);
   endfunction

endpackage

// File: rtl/cn_min_sched_min2_update.sv
// Combinational two-minimum update for one incoming magnitude.
// Strict compares: on ties the earlier element keeps min1, and an equal value
// only displaces min2 when it is strictly smaller than min2.
module min2_update
   import cn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic [DATA_W-1:0] min1,
   input  logic [DATA_W-1:0] min2,
   input  logic [IDX_W-1:0]  idx1,
   input  logic [DATA_W-1:0] x,
   input  logic [IDX_W-1:0]  pos,
   output logic [DATA_W-1:0] next_min1,
   output logic [DATA_W-1:0] next_min2,
   output logic [IDX_W-1:0]  next_idx1
);

   // Compare-and-select: new smallest pushes the old min1 down to min2.
   always_comb begin
      next_min1 = min1;
      next_min2 = min2;
      next_idx1 = idx1;
      if (x < min1) begin
         next_min2 = min1;
         next_min1 = x;
         next_idx1 = pos;
      end else if (x < min2) begin
         next_min2 = x;
      end
   end

endmodule

// File: rtl/cn_min_sched.sv
// Sequencing controller for the min-sum check-node minimum search.
// Accepts one magnitude per cycle for a row of programmable degree and emits
// the (min1, min2, idx1) result over a valid/ready handshake.
// Optional macro CN_SIGN_TRACK_EN adds in_sign / out_sign_par parity tracking.
module cn_min_sched
   import cn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  cfg_deg,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_min1,
   output logic [DATA_W-1:0] out_min2,
   output logic [IDX_W-1:0]  out_idx1,
   output logic              busy,
   output logic              cfg_err
`ifdef CN_SIGN_TRACK_EN
   ,
   input  logic              in_sign,
   output logic              out_sign_par
`endif
);

   localparam logic [DATA_W-1:0] MAX_MAG = DATA_W'(max_mag(DATA_W));

   state_t            state;
   logic [IDX_W-1:0]  deg;
   logic [IDX_W-1:0]  count;
   logic [DATA_W-1:0] min1;
   logic [DATA_W-1:0] min2;
   logic [IDX_W-1:0]  idx1;
   logic [DATA_W-1:0] next_min1;
   logic [DATA_W-1:0] next_min2;
   logic [IDX_W-1:0]  next_idx1;
   logic              accept;
   logic              last;

`ifdef CN_SIGN_TRACK_EN
   logic              par;
`endif

   // in_ready is registered and only high in ACCUM, so it gates acceptance.
   assign accept = in_valid && in_ready;
   assign last   = accept && (count == (deg - IDX_W'(1)));

   min2_update #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_update (
      .min1      (min1),
      .min2      (min2),
      .idx1      (idx1),
      .x         (in_data),
      .pos       (count),
      .next_min1 (next_min1),
      .next_min2 (next_min2),
      .next_idx1 (next_idx1)
   );

   // Row FSM with all outputs registered; the result is captured on the last accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         deg       <= '0;
         count     <= '0;
         min1      <= '0;
         min2      <= '0;
         idx1      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
         out_min1  <= '0;
         out_min2  <= '0;
         out_idx1  <= '0;
`ifdef CN_SIGN_TRACK_EN
         par          <= 1'b0;
         out_sign_par <= 1'b0;
`endif
      end else begin
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_deg >= IDX_W'(2)) begin
                     deg      <= cfg_deg;
                     min1     <= MAX_MAG;
                     min2     <= MAX_MAG;
                     idx1     <= '0;
                     count    <= '0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= ACCUM;
`ifdef CN_SIGN_TRACK_EN
                     par      <= 1'b0;
`endif
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  min1  <= next_min1;
                  min2  <= next_min2;
                  idx1  <= next_idx1;
                  count <= count + IDX_W'(1);
`ifdef CN_SIGN_TRACK_EN
                  par   <= par ^ in_sign;
`endif
                  if (last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_min1  <= next_min1;
                     out_min2  <= next_min2;
                     out_idx1  <= next_idx1;
`ifdef CN_SIGN_TRACK_EN
                     out_sign_par <= par ^ in_sign;
`endif
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cn_min_sched.sv
// Directed testbench for cn_min_sched with hand-computed expected results.
// Honours CN_SIGN_TRACK_EN when defined.
module tb_cn_min_sched;

   localparam int DATA_W = 8;
   localparam int IDX_W  = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic [IDX_W-1:0]  cfg_deg;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_min1;
   logic [DATA_W-1:0] out_min2;
   logic [IDX_W-1:0]  out_idx1;
   logic              busy;
   logic              cfg_err;
`ifdef CN_SIGN_TRACK_EN
   logic              in_sign;
   logic              out_sign_par;
`endif

   int vecCount;
   int missCount;

   cn_min_sched #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_deg   (cfg_deg),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_min1  (out_min1),
      .out_min2  (out_min2),
      .out_idx1  (out_idx1),
      .busy      (busy),
      .cfg_err   (cfg_err)
`ifdef CN_SIGN_TRACK_EN
      ,
      .in_sign      (in_sign),
      .out_sign_par (out_sign_par)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: count it and report a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge; drive and sample there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle with the given degree.
   task automatic startRow(input logic [IDX_W-1:0] deg);
      start   = 1'b1;
      cfg_deg = deg;
      tick();
      start   = 1'b0;
   endtask

   // Present one element and hold it until it is accepted (bounded wait).
   task automatic applyStimulus(input logic [DATA_W-1:0] x, input logic sgn);
      int waitCycles;
      in_valid = 1'b1;
      in_data  = x;
`ifdef CN_SIGN_TRACK_EN
      in_sign  = sgn;
`else
      if (sgn) begin end
`endif
      waitCycles = 0;
      while (!in_ready && waitCycles < 20) begin
         tick();
         waitCycles++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic checkResult(input string tag, input int m1, input int m2, input int ix);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_min1"}, 32'(out_min1), 32'(m1));
      checkOutput({tag, "_min2"}, 32'(out_min2), 32'(m2));
      checkOutput({tag, "_idx1"}, 32'(out_idx1), 32'(ix));
   endtask

   // Release a held result and check the return to IDLE.
   task automatic drainResult(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      rst       = 1'b1;
      start     = 1'b0;
      cfg_deg   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef CN_SIGN_TRACK_EN
      in_sign   = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      tick();

      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
      checkOutput("rst_min1", 32'(out_min1), 32'd0);
      checkOutput("rst_min2", 32'(out_min2), 32'd0);
      checkOutput("rst_idx1", 32'(out_idx1), 32'd0);

      // Row 1: deg 4, 9,3,7,5 back-to-back, signs 1,0,1,1.
      startRow(8'd4);
      checkOutput("r1_in_ready", 32'(in_ready), 32'd1);
      checkOutput("r1_busy", 32'(busy), 32'd1);
      applyStimulus(8'd9, 1'b1);
      applyStimulus(8'd3, 1'b0);
      applyStimulus(8'd7, 1'b1);
      checkOutput("r1_no_early_valid", 32'(out_valid), 32'd0);
      applyStimulus(8'd5, 1'b1);
      checkResult("r1", 3, 5, 1);
      checkOutput("r1_in_ready_low", 32'(in_ready), 32'd0);
`ifdef CN_SIGN_TRACK_EN
      checkOutput("r1_sign_par", 32'(out_sign_par), 32'd1);
`endif
      drainResult("r1");
      checkOutput("r1_min1_kept", 32'(out_min1), 32'd3);

      // Row 2: deg 2, 255 then 255 with a 3-cycle gap; idx1 must restart at 0.
      startRow(8'd2);
      applyStimulus(8'd255, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("r2_gap_in_ready", 32'(in_ready), 32'd1);
         checkOutput("r2_gap_no_valid", 32'(out_valid), 32'd0);
      end
      applyStimulus(8'd255, 1'b0);
      checkResult("r2", 255, 255, 0);
      drainResult("r2");

      // Row 3: deg 3, 4,4,6 tie case, then hold for 5 cycles with a stray start.
      startRow(8'd3);
      applyStimulus(8'd4, 1'b0);
      applyStimulus(8'd4, 1'b0);
      applyStimulus(8'd6, 1'b0);
      checkResult("r3", 4, 4, 0);
      for (int i = 0; i < 5; i++) begin
         start   = (i == 2);
         cfg_deg = 8'd5;
         tick();
         checkOutput("r3_hold_valid", 32'(out_valid), 32'd1);
         checkOutput("r3_hold_min1", 32'(out_min1), 32'd4);
         checkOutput("r3_hold_min2", 32'(out_min2), 32'd4);
         checkOutput("r3_hold_cfg_err", 32'(cfg_err), 32'd0);
         checkOutput("r3_hold_busy", 32'(busy), 32'd1);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b0;
      checkOutput("r3_hs_valid", 32'(out_valid), 32'd0);
      checkOutput("r3_hs_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("r3_hs_start_ignored", 32'(in_ready), 32'd0);
      checkOutput("r3_hs_busy_idle", 32'(busy), 32'd0);

      // Illegal degree: one-cycle cfg_err, no row started.
      startRow(8'd1);
      checkOutput("bad_cfg_err", 32'(cfg_err), 32'd1);
      checkOutput("bad_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("bad_cfg_err_clear", 32'(cfg_err), 32'd0);
      checkOutput("bad_busy_idle", 32'(busy), 32'd0);

      // Reset after 2 of 6 elements, then a fresh deg-3 row 8,6,7.
      startRow(8'd6);
      applyStimulus(8'd1, 1'b0);
      applyStimulus(8'd2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_min1", 32'(out_min1), 32'd0);
      checkOutput("mid_rst_min2", 32'(out_min2), 32'd0);
      checkOutput("mid_rst_idx1", 32'(out_idx1), 32'd0);
      tick();
      startRow(8'd3);
      applyStimulus(8'd8, 1'b1);
      applyStimulus(8'd6, 1'b0);
      applyStimulus(8'd7, 1'b0);
      checkResult("r4", 6, 7, 1);
`ifdef CN_SIGN_TRACK_EN
      checkOutput("r4_sign_par", 32'(out_sign_par), 32'd1);
`endif
      drainResult("r4");

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/cn_min_sched.md
Name: cn_min_sched

Overview:
- Sequencing controller for the min-sum check-node minimum search in the LDPC decoder.
- Accepts one variable-to-check magnitude per cycle over a valid/ready stream for one check-node row of programmable degree.
- Keeps a running (min1, min2, idx1) pair using the same strict-less-than compare-and-select rule as the two-pair merge stage.
- Emits one result per row over a second valid/ready handshake toward the check-to-variable update stage.

Parameters:
- DATA_W, 8, magnitude width.
- IDX_W, 8, index/count width; supports row degree up to 2**IDX_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a row; sampled only in IDLE.
- cfg_deg  in  IDX_W  row degree; latched when start is accepted.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  DATA_W  magnitude.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_min1  out  DATA_W  smallest magnitude of the row.
- out_min2  out  DATA_W  second smallest magnitude of the row.
- out_idx1  out  IDX_W  arrival position (0-based) of min1.
- busy  out  1  high in ACCUM or HOLD.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; in_ready=0, out_valid=0, busy=0, cfg_err=0; out_min1, out_min2, out_idx1 = 0; internal count=0.
- IDLE:
  - start=1 and cfg_deg>=2: latch deg; set min1=min2=all-ones (MAX_MAG); count=0; go to ACCUM next cycle.
  - start=1 and cfg_deg<2: stay in IDLE; cfg_err=1 for exactly one cycle.
- ACCUM:
  - in_ready=1. An element is accepted when in_valid && in_ready.
  - Compare and update for element x at position count:
    - x<min1: min2<=min1, min1<=x, idx1<=count.
    - else if x<min2: min2<=x.
    - else: no change.
  - Comparisons are strict. On ties the earlier element keeps min1. An equal value becomes min2 only if it is strictly less than the current min2.
  - count increments on each accept.
  - When the accepted element has count==deg-1: go to HOLD next cycle; in_ready drops in that cycle.
  - in_valid=0: hold all state; no timeout.
  - start is ignored in ACCUM and HOLD; no cfg_err.
- HOLD:
  - out_valid=1; outputs are stable registered values; in_ready=0.
  - out_valid && out_ready: go to IDLE next cycle; outputs keep their last values; out_valid=0.
  - Latency: out_valid rises the cycle after the last element is accepted.
  - A start arriving in the same cycle as the output handshake is ignored; the first legal start is one cycle later, in IDLE.
- All outputs are registered; there is no combinational path from in_valid/out_ready to any output.
- rst asserted mid-row: the row is abandoned and the block returns to the reset values above; no partial result is emitted.
- Data width: unsigned compare over DATA_W bits; an all-ones input is legal and compares equal to MAX_MAG.

Optional Feature:
- CN_SIGN_TRACK_EN defined:
  - Adds input in_sign (1) and output out_sign_par (1).
  - The parity register clears on start accept and XORs in_sign on every accept.
  - out_sign_par is valid with out_valid; reset value 0.
- Undefined: neither port exists and no parity logic is built.

Decomposition:
- Shared package cn_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - MAX_MAG all-ones constant function of DATA_W.
  - Default DATA_W/IDX_W constants shared with the merge stage.
- One natural sub-module: min2_update, purely combinational.
  - Inputs: min1, min2, idx1, x, pos.
  - Outputs: next min1/min2/idx1.
  - Reusable by a later 2-element-per-cycle variant.

Test Plan:
- Reset, then start with cfg_deg=4; feed 9,3,7,5 back-to-back -> out_valid one cycle after the 4th accept; min1=3, min2=5, idx1=1.
- cfg_deg=3; feed 4,4,6 -> min1=4, idx1=0, min2=4 (tie keeps the earlier element as min1).
- cfg_deg=2 with gaps:
  - Feed 255 then 255, in_valid dropping for 3 cycles between them.
  - Expect min1=255, min2=255, idx1=0.
  - in_ready stays high during the gap.
- Hold out_ready=0 for 5 cycles in HOLD -> out_valid and the outputs stay stable; a start pulse during HOLD is ignored with no cfg_err; handshake -> IDLE.
- start with cfg_deg=1 -> cfg_err for one cycle, busy stays 0. Then rst asserted after 2 of 6 elements of a new row -> all outputs return to 0 and a fresh row runs correctly.
- With CN_SIGN_TRACK_EN: signs 1,0,1,1 on a deg-4 row -> out_sign_par=1.
